// File: rtl/plu_ctrl_pkg.sv
// Purpose : shared types and defaults for the PLU run controller.
// Latency : n/a (types and constants only).
// Backpressure : n/a.
// Contents: state_t (controller FSM states), PLU_LATENCY, PLU_LEN_W.
package plu_ctrl_pkg;

  // Default cycles from a word on dp_counter to its flag on dp_match.
  localparam int PLU_LATENCY = 4;
  // Default width of run length and result counters.
  localparam int PLU_LEN_W   = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_t;

endpackage

// File: rtl/plu_run_controller_if.sv
// Purpose : command, datapath and result signals of the PLU run controller.
// Latency : n/a (wiring only).
// Backpressure : start/start_ready for commands, result_valid/result_ack for results.
// Modports: master = host/datapath side (drives commands, dp_match, ack);
//           slave  = controller side (drives dp_counter, status and results).
interface plu_run_controller_if #(
  parameter int LEN_W = plu_ctrl_pkg::PLU_LEN_W
);

  logic             start;
  logic             start_ready;
  logic [31:0]      cfg_seed;
  logic [31:0]      cfg_step;
  logic [LEN_W-1:0] cfg_len;
  logic             abort;
  logic [31:0]      dp_counter;
  logic             dp_match;
  logic             busy;
  logic             result_valid;
  logic             result_ack;
  logic [LEN_W-1:0] result_matches;
  logic [LEN_W-1:0] result_samples;

  modport master (
    output start, cfg_seed, cfg_step, cfg_len, abort, dp_match, result_ack,
    input  start_ready, dp_counter, busy, result_valid, result_matches, result_samples
  );

  modport slave (
    input  start, cfg_seed, cfg_step, cfg_len, abort, dp_match, result_ack,
    output start_ready, dp_counter, busy, result_valid, result_matches, result_samples
  );

endinterface

// File: rtl/plu_tag_pipe.sv
// Purpose : LATENCY-deep 1-bit shift register marking pipeline slots that carry real samples.
// Latency : din appears on dout exactly LATENCY cycles later.
// Backpressure : none; shifts every cycle, clr empties every slot on the next edge.
// Ports: clk, clr (synchronous clear), din (tag in), dout (tag aligned with dp_match).
module plu_tag_pipe #(
  parameter int LATENCY = plu_ctrl_pkg::PLU_LATENCY
) (
  input  logic clk,
  input  logic clr,
  input  logic din,
  output logic dout
);

  logic [LATENCY-1:0] sr;

  always_ff @(posedge clk) begin
    if (clr) begin
      sr <= '0;
    end else begin
      sr[0] <= din;
      for (int i = 1; i < LATENCY; i++) begin
        sr[i] <= sr[i-1];
      end
    end
  end

  assign dout = sr[LATENCY-1];

endmodule

// File: rtl/plu_run_controller.sv
// Purpose : sequences one PLU run: issues len operand words, counts tag-qualified matches, reports result.
// Latency : first word one cycle after accept; result_valid len+LATENCY+1 cycles after accept.
// Backpressure : start accepted only in IDLE (no queuing); result held in DONE until result_ack.
// Ports: clk, rst (sync, active-high), bus (slave modport: start/cfg_*/abort in,
//        dp_counter out, dp_match in, busy/result_* out, result_ack in).
module plu_run_controller
  import plu_ctrl_pkg::*;
#(
  parameter int LATENCY = PLU_LATENCY,
  parameter int LEN_W   = PLU_LEN_W
) (
  input  logic                 clk,
  input  logic                 rst,
  plu_run_controller_if.slave  bus
);

  // Drain counter only needs to reach LATENCY-1.
  localparam int DW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  state_t           state;
  logic             start_ready_q;
  logic             busy_q;
  logic             result_valid_q;
  logic [31:0]      dp_counter_q;
  logic [31:0]      step_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] issue_idx;
  logic [LEN_W-1:0] match_acc;
  logic [LEN_W-1:0] result_matches_q;
  logic [LEN_W-1:0] result_samples_q;
  logic [DW-1:0]    drain_cnt;

  logic             in_flight;
  logic             tag_in;
  logic             tag_out;
  logic             tag_clr;
  logic             hit;
  logic [LEN_W-1:0] match_nxt;

  assign in_flight = (state == ST_RUN) || (state == ST_DRAIN);

  // Every RUN cycle issues exactly one real word; all other cycles shift in empty slots.
  assign tag_in  = (state == ST_RUN);
  assign tag_clr = rst || (bus.abort && in_flight);

  plu_tag_pipe #(.LATENCY(LATENCY)) u_tag_pipe (
    .clk  (clk),
    .clr  (tag_clr),
    .din  (tag_in),
    .dout (tag_out)
  );

  // Flags from fill/drain/garbage slots carry tag 0 and are dropped here.
  assign hit       = tag_out && bus.dp_match;
  assign match_nxt = match_acc + LEN_W'(hit);

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= ST_IDLE;
      start_ready_q    <= 1'b1;
      busy_q           <= 1'b0;
      result_valid_q   <= 1'b0;
      dp_counter_q     <= '0;
      step_q           <= '0;
      len_q            <= '0;
      issue_idx        <= '0;
      match_acc        <= '0;
      result_matches_q <= '0;
      result_samples_q <= '0;
      drain_cnt        <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          // start_ready is high throughout IDLE, so start alone is an accept;
          // a simultaneous abort is ignored here, so start wins.
          if (bus.start) begin
            step_q        <= bus.cfg_step;
            len_q         <= bus.cfg_len;
            issue_idx     <= '0;
            match_acc     <= '0;
            start_ready_q <= 1'b0;
            if (bus.cfg_len == '0) begin
              state            <= ST_DONE;
              result_valid_q   <= 1'b1;
              result_matches_q <= '0;
              result_samples_q <= '0;
            end else begin
              state        <= ST_RUN;
              busy_q       <= 1'b1;
              dp_counter_q <= bus.cfg_seed;
            end
          end
        end

        ST_RUN: begin
          if (bus.abort) begin
            state         <= ST_IDLE;
            busy_q        <= 1'b0;
            start_ready_q <= 1'b1;
          end else begin
            match_acc <= match_nxt;
            issue_idx <= issue_idx + LEN_W'(1);
            if (issue_idx == len_q - LEN_W'(1)) begin
              state     <= ST_DRAIN;
              drain_cnt <= '0;
            end else begin
              dp_counter_q <= dp_counter_q + step_q;
            end
          end
        end

        ST_DRAIN: begin
          if (bus.abort) begin
            state         <= ST_IDLE;
            busy_q        <= 1'b0;
            start_ready_q <= 1'b1;
          end else if (drain_cnt == DW'(LATENCY - 1)) begin
            // The last word's flag arrives in this cycle, so fold it in directly.
            state            <= ST_DONE;
            busy_q           <= 1'b0;
            result_valid_q   <= 1'b1;
            match_acc        <= match_nxt;
            result_matches_q <= match_nxt;
            result_samples_q <= issue_idx;
          end else begin
            match_acc <= match_nxt;
            drain_cnt <= drain_cnt + DW'(1);
          end
        end

        ST_DONE: begin
          if (bus.result_ack) begin
            state          <= ST_IDLE;
            result_valid_q <= 1'b0;
            start_ready_q  <= 1'b1;
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.start_ready    = start_ready_q;
  assign bus.busy           = busy_q;
  assign bus.result_valid   = result_valid_q;
  assign bus.dp_counter     = dp_counter_q;
  assign bus.result_matches = result_matches_q;
  assign bus.result_samples = result_samples_q;

endmodule
